// File: rtl/sha256_pkg.sv
// Shared types and constants for the sha256 header sequencer.
// Holds the IV, controller states and the fixed padding tails.
package sha256_pkg;

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // Tail of block 2: 0x80 marker, zero fill, 640-bit length.
    localparam logic [383:0] PAD_640 = {32'h80000000, 288'b0, 64'd640};

    // Tail of the digest block: 0x80 marker, zero fill, 256-bit length.
    localparam logic [255:0] PAD_256 = {32'h80000000, 160'b0, 64'd256};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        B1_GO   = 3'd1,
        B1_WAIT = 3'd2,
        B2_GO   = 3'd3,
        B2_WAIT = 3'd4,
        D_GO    = 3'd5,
        D_WAIT  = 3'd6,
        DONE    = 3'd7
    } ctrl_state_t;

    function automatic logic is_go(ctrl_state_t s);
        return (s == B1_GO) || (s == B2_GO) || (s == D_GO);
    endfunction

    function automatic logic is_active(ctrl_state_t s);
        return (s != IDLE) && (s != DONE);
    endfunction

endpackage

// File: rtl/sha256_header_ctrl_if.sv
// Link between the header sequencer and the shared compression core.
// The sequencer is master; the core is slave.
interface sha256_header_ctrl_if;

    logic         core_enable;
    logic [511:0] core_data;
    logic [255:0] core_current_hash;
    logic [255:0] core_hash;
    logic         core_hash_done;

    modport master (
        output core_enable,
        output core_data,
        output core_current_hash,
        input  core_hash,
        input  core_hash_done
    );

    modport slave (
        input  core_enable,
        input  core_data,
        input  core_current_hash,
        output core_hash,
        output core_hash_done
    );

endinterface

// File: rtl/sha256_header_ctrl.sv
// Drives one shared sha256 core through the two header blocks
// and, when DOUBLE is set, a third pass over the digest.
module sha256_header_ctrl
    import sha256_pkg::*;
#(
    parameter bit DOUBLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [639:0]         header,
    output logic                 busy,
    output logic [255:0]         digest,
    output logic                 digest_valid,
    sha256_header_ctrl_if.master core
);

    ctrl_state_t  state_q, state_n;
    logic [639:0] hdr_q, hdr_n;
    logic [255:0] mid_q, mid_n;
    logic [255:0] digest_n;
    logic         valid_n;
    logic         busy_n;
    logic         enable_q, enable_n;
    logic [511:0] data_q, data_n;
    logic [255:0] chash_q, chash_n;

    assign core.core_enable       = enable_q;
    assign core.core_data         = data_q;
    assign core.core_current_hash = chash_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            mid_q        <= '0;
            busy         <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            enable_q     <= 1'b0;
            data_q       <= '0;
            chash_q      <= '0;
        end else begin
            state_q      <= state_n;
            hdr_q        <= hdr_n;
            mid_q        <= mid_n;
            busy         <= busy_n;
            digest       <= digest_n;
            digest_valid <= valid_n;
            enable_q     <= enable_n;
            data_q       <= data_n;
            chash_q      <= chash_n;
        end
    end

    // Next state; done pulses outside the *_WAIT states fall through.
    always_comb begin
        state_n  = state_q;
        hdr_n    = hdr_q;
        mid_n    = mid_q;
        digest_n = digest;
        valid_n  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    hdr_n   = header;
                    state_n = B1_GO;
                end
            end
            B1_GO:   state_n = B1_WAIT;
            B1_WAIT: begin
                if (core.core_hash_done) begin
                    mid_n   = core.core_hash;
                    state_n = B2_GO;
                end
            end
            B2_GO:   state_n = B2_WAIT;
            B2_WAIT: begin
                if (core.core_hash_done) begin
                    if (DOUBLE) begin
                        mid_n   = core.core_hash;
                        state_n = D_GO;
                    end else begin
                        digest_n = core.core_hash;
                        valid_n  = 1'b1;
                        state_n  = DONE;
                    end
                end
            end
            D_GO:    state_n = D_WAIT;
            D_WAIT: begin
                if (core.core_hash_done) begin
                    digest_n = core.core_hash;
                    valid_n  = 1'b1;
                    state_n  = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Core-facing outputs are registered from the upcoming state.
    always_comb begin
        enable_n = is_go(state_n);
        busy_n   = is_active(state_n);
        data_n   = data_q;
        chash_n  = chash_q;
        unique case (state_n)
            B1_GO, B1_WAIT: begin
                data_n  = hdr_n[639:128];
                chash_n = SHA256_IV;
            end
            B2_GO, B2_WAIT: begin
                data_n  = {hdr_n[127:0], PAD_640};
                chash_n = mid_n;
            end
            D_GO, D_WAIT: begin
                data_n  = {mid_n, PAD_256};
                chash_n = SHA256_IV;
            end
            default: begin
                data_n  = data_q;
                chash_n = chash_q;
            end
        endcase
    end

endmodule
